// File: rtl/pool_buffer_pkg.sv
// Shared definitions for the pooled-result buffer: default geometry, FSM encoding,
// output beat layout and the ReLU clamp applied on write.
package pool_buffer_pkg;

    localparam int unsigned DefSize  = 7;
    localparam int unsigned DefBanks = 4;
    localparam int unsigned DefDepth = DefSize * DefSize;
    localparam int unsigned DefTotal = DefBanks * DefDepth;
    localparam int unsigned DefIdxW  = $clog2(DefTotal);
    localparam int unsigned DataW    = 16;

    typedef enum logic {
        StFill  = 1'b0,
        StDrain = 1'b1
    } state_e;

    typedef struct packed {
        logic [DataW-1:0] data;
        logic [1:0]       bank;
        logic             last;
    } beat_t;

    // Two's-complement clamp: negative values become zero.
    function automatic logic [DataW-1:0] relu_clamp(input logic [DataW-1:0] v);
        return v[DataW-1] ? '0 : v;
    endfunction

endpackage

// File: rtl/pool_buffer_if.sv
// Pooling-engine write side and downstream stream side of pool_buffer.
interface pool_buffer_if;

    logic [15:0] pool_result;
    logic [15:0] addr;
    logic [1:0]  history;
    logic        com_end;
    logic        done_pool;

    logic [15:0] o_data;
    logic [1:0]  o_bank;
    logic        o_valid;
    logic        o_last;
    logic        o_ready;
    logic        busy;
    logic        err;

    modport master (
        output pool_result, addr, history, com_end, done_pool, o_ready,
        input  o_data, o_bank, o_valid, o_last, busy, err
    );

    modport slave (
        input  pool_result, addr, history, com_end, done_pool, o_ready,
        output o_data, o_bank, o_valid, o_last, busy, err
    );

endinterface

// File: rtl/pool_buf_ram.sv
// Simple dual-port synchronous RAM: one write port, one registered read port.
module pool_buf_ram
    import pool_buffer_pkg::*;
#(
    parameter int unsigned Words = DefTotal,
    parameter int unsigned IdxW  = DefIdxW,
    parameter int unsigned Width = DataW
) (
    input  logic             clk_i,
    input  logic             we_i,
    input  logic [IdxW-1:0]  waddr_i,
    input  logic [Width-1:0] wdata_i,
    input  logic             re_i,
    input  logic [IdxW-1:0]  raddr_i,
    output logic [Width-1:0] rdata_o
);

    logic [Width-1:0] mem_q [Words];
    logic [Width-1:0] rdata_q;

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
        if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/pool_buffer.sv
// Banked buffer for pooled results: fills from the pooling engine, then streams every
// entry (unwritten ones as zero) bank by bank through a 2-deep read-ahead FIFO.
module pool_buffer
    import pool_buffer_pkg::*;
#(
    parameter int unsigned SIZE  = DefSize,
    parameter int unsigned BANKS = DefBanks,
    parameter bit          RELU  = 1'b1
) (
    input  logic          clk,
    input  logic          reset_n,
    pool_buffer_if.slave  bus
);

    localparam int unsigned DEPTH  = SIZE * SIZE;
    localparam int unsigned TOTAL  = BANKS * DEPTH;
    localparam int unsigned IDX_W  = $clog2(TOTAL);
    localparam int unsigned ADDR_W = $clog2(DEPTH);

    state_e              state_q, state_d;
    logic [TOTAL-1:0]    written_q, written_d;
    logic [ADDR_W-1:0]   rd_addr_q, rd_addr_d;
    logic [1:0]          rd_bank_q, rd_bank_d;
    logic                rd_end_q, rd_end_d;
    logic                err_q, err_d;

    logic                rd_vld_q, rd_vld_d;
    logic                rd_mask_q, rd_mask_d;
    logic [1:0]          rd_bank_p_q, rd_bank_p_d;
    logic                rd_last_p_q, rd_last_p_d;

    beat_t               fifo_q [2];
    beat_t               fifo_d [2];
    logic                wr_ptr_q, wr_ptr_d;
    logic                rd_ptr_q, rd_ptr_d;
    logic [1:0]          cnt_q, cnt_d;

    logic                wr_in_range, wr_en;
    logic [IDX_W-1:0]    wr_idx, rd_idx;
    logic [DataW-1:0]    wr_data, ram_rdata;
    logic                issue, pop, last_pop, rd_is_last;
    beat_t               head, beat_in;

    assign wr_in_range = (32'(bus.addr) < DEPTH) && (32'(bus.history) < BANKS);
    assign wr_en       = (state_q == StFill) && bus.com_end && wr_in_range;
    assign wr_idx      = IDX_W'(32'(bus.history) * DEPTH + 32'(bus.addr));
    assign wr_data     = RELU ? relu_clamp(bus.pool_result) : bus.pool_result;

    assign rd_idx      = IDX_W'(32'(rd_bank_q) * DEPTH + 32'(rd_addr_q));
    assign rd_is_last  = (rd_bank_q == 2'(BANKS - 1)) && (rd_addr_q == ADDR_W'(DEPTH - 1));

    assign head     = fifo_q[rd_ptr_q];
    assign pop      = (cnt_q != 2'd0) && bus.o_ready;
    assign last_pop = pop && head.last;

    // Count the read in flight so the FIFO can never overflow, but credit a same-cycle
    // pop so a continuously ready consumer sees one beat per cycle.
    assign issue = (state_q == StDrain) && !rd_end_q &&
                   ((3'(cnt_q) + 3'(rd_vld_q)) <= (3'd1 + 3'(pop)));

    pool_buf_ram #(
        .Words (TOTAL),
        .IdxW  (IDX_W),
        .Width (DataW)
    ) u_ram (
        .clk_i   (clk),
        .we_i    (wr_en),
        .waddr_i (wr_idx),
        .wdata_i (wr_data),
        .re_i    (issue),
        .raddr_i (rd_idx),
        .rdata_o (ram_rdata)
    );

    always_comb begin : ctrl_next
        state_d   = state_q;
        written_d = written_q;
        rd_addr_d = rd_addr_q;
        rd_bank_d = rd_bank_q;
        rd_end_d  = rd_end_q;
        err_d     = err_q;

        if (bus.com_end && ((state_q == StDrain) || !wr_in_range)) begin
            err_d = 1'b1;
        end
        if (wr_en) begin
            written_d[wr_idx] = 1'b1;
        end

        case (state_q)
            StFill: begin
                if (bus.done_pool) begin
                    state_d = StDrain;
                end
            end
            StDrain: begin
                if (issue) begin
                    if (rd_addr_q == ADDR_W'(DEPTH - 1)) begin
                        rd_addr_d = '0;
                        if (rd_bank_q == 2'(BANKS - 1)) begin
                            rd_end_d = 1'b1;
                        end else begin
                            rd_bank_d = rd_bank_q + 2'd1;
                        end
                    end else begin
                        rd_addr_d = rd_addr_q + ADDR_W'(1);
                    end
                end
                // Memory contents survive; only the written map is re-armed.
                if (last_pop) begin
                    state_d   = StFill;
                    written_d = '0;
                    rd_addr_d = '0;
                    rd_bank_d = '0;
                    rd_end_d  = 1'b0;
                end
            end
            default: state_d = StFill;
        endcase
    end

    always_comb begin : pipe_next
        rd_vld_d    = issue;
        rd_mask_d   = written_q[rd_idx];
        rd_bank_p_d = rd_bank_q;
        rd_last_p_d = rd_is_last;
    end

    always_comb begin : fifo_next
        beat_in.data = rd_mask_q ? ram_rdata : '0;
        beat_in.bank = rd_bank_p_q;
        beat_in.last = rd_last_p_q;

        fifo_d   = fifo_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (rd_vld_q) begin
            fifo_d[wr_ptr_q] = beat_in;
            wr_ptr_d         = ~wr_ptr_q;
        end
        if (pop) begin
            rd_ptr_d = ~rd_ptr_q;
        end
        cnt_d = cnt_q + 2'(rd_vld_q) - 2'(pop);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= StFill;
            written_q   <= '0;
            rd_addr_q   <= '0;
            rd_bank_q   <= '0;
            rd_end_q    <= 1'b0;
            err_q       <= 1'b0;
            rd_vld_q    <= 1'b0;
            rd_mask_q   <= 1'b0;
            rd_bank_p_q <= '0;
            rd_last_p_q <= 1'b0;
            fifo_q      <= '{default: '0};
            wr_ptr_q    <= 1'b0;
            rd_ptr_q    <= 1'b0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            written_q   <= written_d;
            rd_addr_q   <= rd_addr_d;
            rd_bank_q   <= rd_bank_d;
            rd_end_q    <= rd_end_d;
            err_q       <= err_d;
            rd_vld_q    <= rd_vld_d;
            rd_mask_q   <= rd_mask_d;
            rd_bank_p_q <= rd_bank_p_d;
            rd_last_p_q <= rd_last_p_d;
            fifo_q      <= fifo_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            cnt_q       <= cnt_d;
        end
    end

    assign bus.o_valid = (cnt_q != 2'd0);
    assign bus.o_data  = bus.o_valid ? head.data : '0;
    assign bus.o_bank  = bus.o_valid ? head.bank : '0;
    assign bus.o_last  = bus.o_valid && head.last;
    assign bus.busy    = (state_q == StDrain);
    assign bus.err     = err_q;

endmodule

// File: tb/tb_pool_buffer.sv
// Directed bench for pool_buffer: table-driven sparse/ReLU fill plus hand-written
// sequences for full drain, backpressure, simultaneous events, resets and errors.
module tb_pool_buffer;

    localparam int NB = 4;
    localparam int ND = 49;
    localparam int NT = NB * ND;

    typedef struct {
        int bank;
        int addr;
        int value;
        int expect_v;
    } vec_t;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    pool_buffer_if bus ();

    pool_buffer #(
        .SIZE  (7),
        .BANKS (4),
        .RELU  (1'b1)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    int total = 0;
    int bad = 0;

    logic [15:0] exp_mem [NB][ND];
    bit          exp_wr  [NB][ND];
    logic [15:0] got_data [NT];
    logic [1:0]  got_bank [NT];
    bit          got_last [NT];
    int          n_got;
    int          gaps;
    vec_t        vecs [6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0d (0x%0h) required %0d (0x%0h)", name, act, act, req, req);
        end
    endtask

    task automatic model_clear();
        for (int b = 0; b < NB; b++) begin
            for (int a = 0; a < ND; a++) begin
                exp_wr[b][a] = 1'b0;
            end
        end
    endtask

    // Called at a negedge; returns at the next negedge with com_end low.
    task automatic wr(input int b, input int a, input int v);
        bus.com_end     = 1'b1;
        bus.history     = 2'(b);
        bus.addr        = 16'(a);
        bus.pool_result = 16'(v);
        if (a < ND && b < NB) begin
            exp_mem[b][a] = (v < 0) ? 16'h0 : 16'(v);
            exp_wr[b][a]  = 1'b1;
        end
        @(negedge clk);
        bus.com_end = 1'b0;
    endtask

    task automatic fill_all(input int k);
        for (int b = 0; b < NB; b++) begin
            for (int a = 0; a < ND; a++) begin
                wr(b, a, k + b * 100 + a);
            end
        end
    endtask

    task automatic start_drain();
        bus.done_pool = 1'b1;
        @(negedge clk);
        bus.done_pool = 1'b0;
        check("busy_after_done", 32'(bus.busy), 32'd1);
    endtask

    task automatic do_reset();
        bus.com_end   = 1'b0;
        bus.done_pool = 1'b0;
        bus.o_ready   = 1'b0;
        reset_n       = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        model_clear();
    endtask

    task automatic collect(input int max_beats, input bit bp, input bit full,
                           input int inj_at, input int inj_b, input int inj_a, input int inj_v);
        int          cyc = 0;
        bit          held = 1'b0;
        bit          rdy;
        bit          inj_done = 1'b0;
        bit          inj_active = 1'b0;
        logic [15:0] hd = '0;
        logic [1:0]  hb = '0;
        logic        hl = 1'b0;
        n_got = 0;
        gaps  = 0;
        while (n_got < max_beats && cyc < 4000) begin
            if (inj_active) begin
                bus.com_end = 1'b0;
                inj_active  = 1'b0;
            end
            if (n_got == inj_at && !inj_done) begin
                bus.com_end     = 1'b1;
                bus.history     = 2'(inj_b);
                bus.addr        = 16'(inj_a);
                bus.pool_result = 16'(inj_v);
                inj_active      = 1'b1;
                inj_done        = 1'b1;
            end
            if (held) begin
                check("hold_stable", {12'd0, bus.o_valid, bus.o_last, bus.o_bank, bus.o_data},
                      {12'd0, 1'b1, hl, hb, hd});
            end
            rdy = bp ? ($urandom_range(0, 2) != 0) : 1'b1;
            bus.o_ready = rdy;
            if (bus.o_valid) begin
                if (rdy) begin
                    got_data[n_got] = bus.o_data;
                    got_bank[n_got] = bus.o_bank;
                    got_last[n_got] = bus.o_last;
                    n_got++;
                end
                held = !rdy;
                hd   = bus.o_data;
                hb   = bus.o_bank;
                hl   = bus.o_last;
            end else begin
                held = 1'b0;
                if (!bp && n_got > 0) gaps++;
            end
            @(negedge clk);
            cyc++;
        end
        bus.com_end = 1'b0;
        bus.o_ready = 1'b0;
        check("drain_beat_count", 32'(n_got), 32'(max_beats));
        if (full && n_got == max_beats) begin
            check("end_valid_low", 32'(bus.o_valid), 32'd0);
            check("end_last_low", 32'(bus.o_last), 32'd0);
            check("end_busy_low", 32'(bus.busy), 32'd0);
        end
    endtask

    task automatic check_all(input string name);
        logic [15:0] e;
        int          b;
        int          a;
        for (int i = 0; i < n_got; i++) begin
            b = i / ND;
            a = i % ND;
            e = exp_wr[b][a] ? exp_mem[b][a] : 16'h0;
            check($sformatf("%s_beat%0d", name, i),
                  {13'd0, got_last[i], got_bank[i], got_data[i]},
                  {13'd0, (i == NT - 1), 2'(b), e});
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n_last;
        bus.pool_result = '0;
        bus.addr        = '0;
        bus.history     = '0;
        bus.com_end     = 1'b0;
        bus.done_pool   = 1'b0;
        bus.o_ready     = 1'b0;
        model_clear();

        vecs[0] = '{1, 3, -5, 0};
        vecs[1] = '{2, 0, 7, 7};
        vecs[2] = '{0, 48, -1, 0};
        vecs[3] = '{3, 48, 32767, 32767};
        vecs[4] = '{3, 0, -32768, 0};
        vecs[5] = '{1, 20, 300, 300};

        // Reset values
        repeat (2) @(negedge clk);
        check("rst_valid", 32'(bus.o_valid), 32'd0);
        check("rst_last", 32'(bus.o_last), 32'd0);
        check("rst_data", 32'(bus.o_data), 32'd0);
        check("rst_bank", 32'(bus.o_bank), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_err", 32'(bus.err), 32'd0);
        reset_n = 1'b1;
        @(negedge clk);

        // Full fill, continuous drain
        fill_all(0);
        start_drain();
        collect(NT, 1'b0, 1'b1, -1, 0, 0, 0);
        check_all("full");
        check("full_gaps", 32'(gaps), 32'd0);
        check("full_last_value", 32'(got_data[NT-1]), 32'd348);
        n_last = 0;
        for (int i = 0; i < n_got; i++) n_last += int'(got_last[i]);
        check("full_last_count", 32'(n_last), 32'd1);
        check("full_err", 32'(bus.err), 32'd0);
        model_clear();

        // Sparse fill with ReLU, starting in the cycle right after the last handshake
        for (int i = 0; i < 6; i++) begin
            wr(vecs[i].bank, vecs[i].addr, vecs[i].value);
        end
        start_drain();
        collect(NT, 1'b0, 1'b1, -1, 0, 0, 0);
        for (int i = 0; i < 6; i++) begin
            check($sformatf("vec%0d", i), 32'(got_data[vecs[i].bank * ND + vecs[i].addr]),
                  32'(16'(vecs[i].expect_v)));
        end
        check_all("sparse");
        check("sparse_err", 32'(bus.err), 32'd0);
        model_clear();

        // Random backpressure
        fill_all(1000);
        start_drain();
        collect(NT, 1'b1, 1'b1, -1, 0, 0, 0);
        check_all("bp");
        model_clear();

        // com_end and done_pool together
        @(negedge clk);
        bus.o_ready = 1'b0;
        bus.done_pool = 1'b1;
        wr(0, 0, 9);
        bus.done_pool = 1'b0;
        check("sim_busy", 32'(bus.busy), 32'd1);
        check("sim_valid_t1", 32'(bus.o_valid), 32'd0);
        @(negedge clk);
        check("sim_valid_t2", 32'(bus.o_valid), 32'd0);
        @(negedge clk);
        check("sim_valid_t3", 32'(bus.o_valid), 32'd1);
        check("sim_first_data", 32'(bus.o_data), 32'd9);
        check("sim_first_bank", 32'(bus.o_bank), 32'd0);
        collect(NT, 1'b0, 1'b1, -1, 0, 0, 0);
        check_all("sim");
        model_clear();

        // Reset mid-drain after 50 beats
        fill_all(2000);
        start_drain();
        collect(50, 1'b0, 1'b0, -1, 0, 0, 0);
        reset_n = 1'b0;
        #1;
        check("mid_rst_valid", 32'(bus.o_valid), 32'd0);
        check("mid_rst_last", 32'(bus.o_last), 32'd0);
        check("mid_rst_data", 32'(bus.o_data), 32'd0);
        check("mid_rst_bank", 32'(bus.o_bank), 32'd0);
        check("mid_rst_busy", 32'(bus.busy), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        model_clear();
        @(negedge clk);
        wr(2, 7, -3);
        wr(0, 48, 123);
        wr(3, 10, 4321);
        start_drain();
        collect(NT, 1'b0, 1'b1, -1, 0, 0, 0);
        check_all("post_rst");
        model_clear();

        // Out-of-range write
        do_reset();
        check("err_after_reset", 32'(bus.err), 32'd0);
        wr(0, 49, 55);
        check("err_oor", 32'(bus.err), 32'd1);
        wr(1, 2, 21);
        start_drain();
        collect(NT, 1'b0, 1'b1, -1, 0, 0, 0);
        check_all("oor");
        check("err_oor_sticky", 32'(bus.err), 32'd1);

        // Write attempted mid-drain
        do_reset();
        check("err_cleared", 32'(bus.err), 32'd0);
        wr(0, 1, 11);
        wr(3, 6, 66);
        start_drain();
        collect(NT, 1'b0, 1'b1, 20, 3, 6, 999);
        check_all("drainwr");
        check("err_drain_write", 32'(bus.err), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
